// File: rtl/sr_flag_bank_pkg.sv
// Shared constants and helpers for the clocked SR flag bank.
package sr_bank_pkg;

    localparam int MODE_RST_DOM = 0;
    localparam int MODE_SET_DOM = 1;
    localparam int MODE_TOGGLE  = 2;

    localparam int unsigned MAX_CNT_W = 32;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [MAX_CNT_W-1:0] sat_inc(
        input logic [MAX_CNT_W-1:0] cnt,
        input int unsigned          width
    );
        logic [MAX_CNT_W-1:0] max_val;
        if (width >= MAX_CNT_W)
            max_val = '1;
        else
            max_val = (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
        if (cnt >= max_val)
            return max_val;
        else
            return cnt + MAX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sr_flag_bank_if.sv
// Strobe/status bundle between event sources, the flag bank and its consumers.
interface sr_flag_bank_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 4
);

    logic [CHANNELS-1:0]       set;
    logic [CHANNELS-1:0]       clr;
    logic                      cnt_clr;
    logic [CHANNELS-1:0]       q;
    logic [CHANNELS-1:0]       qn;
    logic [CHANNELS-1:0]       rise;
    logic                      any_q;
    logic [CHANNELS*CNT_W-1:0] set_cnt;

    modport master (
        output set, clr, cnt_clr,
        input  q, qn, rise, any_q, set_cnt
    );

    modport slave (
        input  set, clr, cnt_clr,
        output q, qn, rise, any_q, set_cnt
    );

endinterface

// File: rtl/sr_flag_bank_cell.sv
// One flag channel: optional strobe qualification, q/qn/rise and a saturating rise counter.
// SR_BANK_FILTER_EN requires each strobe to be high on two consecutive edges before it acts.
module sr_flag_cell
    import sr_bank_pkg::*;
#(
    parameter int MODE  = MODE_RST_DOM,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             clr,
    input  logic             cnt_clr,
    output logic             q,
    output logic             qn,
    output logic             rise,
    output logic [CNT_W-1:0] cnt
);

    logic set_eff;
    logic clr_eff;
    logic q_next;
    logic rise_next;

`ifdef SR_BANK_FILTER_EN
    logic set_d;
    logic clr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            set_d <= 1'b0;
            clr_d <= 1'b0;
        end else begin
            set_d <= set;
            clr_d <= clr;
        end
    end

    assign set_eff = set & set_d;
    assign clr_eff = clr & clr_d;
`else
    assign set_eff = set;
    assign clr_eff = clr;
`endif

    always_comb begin
        q_next = q;
        unique case ({set_eff, clr_eff})
            2'b10: q_next = 1'b1;
            2'b01: q_next = 1'b0;
            2'b11: begin
                if (MODE == MODE_SET_DOM)
                    q_next = 1'b1;
                else if (MODE == MODE_TOGGLE)
                    q_next = ~q;
                else
                    q_next = 1'b0;
            end
            default: q_next = q;
        endcase
        rise_next = q_next & ~q;
    end

    // qn is its own register so it stays the complement of q even across reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            qn   <= 1'b1;
            rise <= 1'b0;
            cnt  <= '0;
        end else begin
            q    <= q_next;
            qn   <= ~q_next;
            rise <= rise_next;
            if (cnt_clr)
                cnt <= '0;
            else if (rise_next)
                cnt <= CNT_W'(sat_inc(MAX_CNT_W'(cnt), CNT_W));
        end
    end

endmodule

// File: rtl/sr_flag_bank.sv
// Parametrised bank of clocked SR flags with collision policy, rise pulses and event counters.
// Optional strobe glitch filter enabled by defining SR_BANK_FILTER_EN.
module sr_flag_bank
    import sr_bank_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int MODE     = MODE_RST_DOM,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    sr_flag_bank_if.slave   bus
);

    if (MODE > MODE_TOGGLE) begin : g_bad_mode
        $error("sr_flag_bank: MODE must be 0, 1 or 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("sr_flag_bank: CHANNELS must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > int'(MAX_CNT_W)) begin : g_bad_cnt_w
        $error("sr_flag_bank: CNT_W out of range");
    end

    logic [CHANNELS-1:0]       q_w;
    logic [CHANNELS-1:0]       qn_w;
    logic [CHANNELS-1:0]       rise_w;
    logic [CHANNELS*CNT_W-1:0] cnt_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        sr_flag_cell #(
            .MODE  (MODE),
            .CNT_W (CNT_W)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .set     (bus.set[i]),
            .clr     (bus.clr[i]),
            .cnt_clr (bus.cnt_clr),
            .q       (q_w[i]),
            .qn      (qn_w[i]),
            .rise    (rise_w[i]),
            .cnt     (cnt_w[i*CNT_W +: CNT_W])
        );
    end

    assign bus.q       = q_w;
    assign bus.qn      = qn_w;
    assign bus.rise    = rise_w;
    assign bus.set_cnt = cnt_w;
    assign bus.any_q   = |q_w;

endmodule

// File: tb/tb_sr_flag_bank.sv
// Directed bench for sr_flag_bank: four instances (three collision modes, one 2-bit counter).
// Default build covers every behaviour; SR_BANK_FILTER_EN build covers reset and the filter.
module tb_sr_flag_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] set_v;
    logic [7:0] clr_v;
    logic       cnt_clr_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sr_flag_bank_if #(.CHANNELS(8), .CNT_W(4)) b0 ();
    sr_flag_bank_if #(.CHANNELS(8), .CNT_W(4)) b1 ();
    sr_flag_bank_if #(.CHANNELS(8), .CNT_W(4)) b2 ();
    sr_flag_bank_if #(.CHANNELS(8), .CNT_W(2)) bs ();

    assign b0.set = set_v;  assign b0.clr = clr_v;  assign b0.cnt_clr = cnt_clr_v;
    assign b1.set = set_v;  assign b1.clr = clr_v;  assign b1.cnt_clr = cnt_clr_v;
    assign b2.set = set_v;  assign b2.clr = clr_v;  assign b2.cnt_clr = cnt_clr_v;
    assign bs.set = set_v;  assign bs.clr = clr_v;  assign bs.cnt_clr = cnt_clr_v;

    sr_flag_bank #(.CHANNELS(8), .MODE(0), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    sr_flag_bank #(.CHANNELS(8), .MODE(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    sr_flag_bank #(.CHANNELS(8), .MODE(2), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    sr_flag_bank #(.CHANNELS(8), .MODE(0), .CNT_W(2)) duts (.clk(clk), .rst(rst), .bus(bs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; set_v = '0; clr_v = '0; cnt_clr_v = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; set_v = 8'hFF; clr_v = '0; cnt_clr_v = 1'b0;
        tick();
        tick();
        chk("rst_q",     32'(b0.q),       32'h0);
        chk("rst_qn",    32'(b0.qn),      32'hFF);
        chk("rst_rise",  32'(b0.rise),    32'h0);
        chk("rst_cnt",   b0.set_cnt,      32'h0);
        chk("rst_any",   32'(b0.any_q),   32'h0);
        chk("rst_qn_m2", 32'(b2.qn),      32'hFF);

`ifdef SR_BANK_FILTER_EN
        do_reset();
        set_v = 8'h08;
        tick();
        chk("flt_pulse_q", 32'(b0.q), 32'h0);
        set_v = 8'h00;
        tick();
        chk("flt_pulse_q2", 32'(b0.q), 32'h0);
        chk("flt_pulse_rise", 32'(b0.rise), 32'h0);
        set_v = 8'h08;
        tick();
        chk("flt_hold_e1_q", 32'(b0.q), 32'h0);
        tick();
        chk("flt_hold_e2_q", 32'(b0.q), 32'h08);
        chk("flt_hold_rise", 32'(b0.rise), 32'h08);
        set_v = 8'h00;
        tick();
        chk("flt_after_rise", 32'(b0.rise), 32'h0);
        chk("flt_after_q", 32'(b0.q), 32'h08);
        chk("flt_cnt", b0.set_cnt, 32'h0000_1000);
`else
        // Set/clear latency and rise behaviour on channel 3.
        rst = 1'b0; set_v = 8'h08;
        tick();
        chk("set3_q",    32'(b0.q),     32'h08);
        chk("set3_qn",   32'(b0.qn),    32'hF7);
        chk("set3_rise", 32'(b0.rise),  32'h08);
        chk("set3_cnt",  b0.set_cnt,    32'h0000_1000);
        chk("set3_any",  32'(b0.any_q), 32'h1);
        set_v = 8'h00; clr_v = 8'h08;
        tick();
        chk("clr3_q",    32'(b0.q),     32'h00);
        chk("clr3_rise", 32'(b0.rise),  32'h00);
        chk("clr3_cnt",  b0.set_cnt,    32'h0000_1000);
        chk("clr3_any",  32'(b0.any_q), 32'h0);
        clr_v = 8'h00; set_v = 8'h08;
        tick();
        chk("reset3_cnt", b0.set_cnt, 32'h0000_2000);
        tick();
        chk("hold3_q",    32'(b0.q),    32'h08);
        chk("hold3_rise", 32'(b0.rise), 32'h00);
        chk("hold3_cnt",  b0.set_cnt,   32'h0000_2000);

        // Collision on channel 0, held four cycles.
        do_reset();
        set_v = 8'h01; clr_v = 8'h01;
        tick();
        chk("col_m0_q", 32'(b0.q), 32'h00);
        chk("col_m1_q", 32'(b1.q), 32'h01);
        chk("col_m2_q1", 32'(b2.q), 32'h01);
        tick();
        chk("col_m2_q2", 32'(b2.q), 32'h00);
        tick();
        chk("col_m2_q3", 32'(b2.q), 32'h01);
        chk("col_m2_rise3", 32'(b2.rise), 32'h01);
        tick();
        chk("col_m2_q4",   32'(b2.q),    32'h00);
        chk("col_m2_cnt",  b2.set_cnt,   32'h2);
        chk("col_m1_cnt",  b1.set_cnt,   32'h1);
        chk("col_m0_cnt",  b0.set_cnt,   32'h0);

        // Saturation on channel 1 of the 2-bit counter instance.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_v = 8'h02; clr_v = 8'h00;
            tick();
            chk($sformatf("sat_cnt_%0d", k), (32'(bs.set_cnt) >> 2) & 32'h3,
                (k < 3) ? 32'(k + 1) : 32'h3);
            set_v = 8'h00; clr_v = 8'h02;
            tick();
        end
        set_v = 8'h02; clr_v = 8'h00; cnt_clr_v = 1'b1;
        tick();
        chk("cntclr_rise", 32'(bs.rise),    32'h02);
        chk("cntclr_cnt",  32'(bs.set_cnt), 32'h0);
        cnt_clr_v = 1'b0; set_v = 8'h00;

        // Mid-operation reset.
        do_reset();
        set_v = 8'hA5;
        tick();
        chk("mid_q",   32'(b0.q),   32'hA5);
        chk("mid_cnt", b0.set_cnt,  32'h1010_0101);
        rst = 1'b1; set_v = 8'hFF;
        tick();
        chk("mid_rst_q",    32'(b0.q),     32'h00);
        chk("mid_rst_qn",   32'(b0.qn),    32'hFF);
        chk("mid_rst_rise", 32'(b0.rise),  32'h00);
        chk("mid_rst_cnt",  b0.set_cnt,    32'h0);
        chk("mid_rst_any",  32'(b0.any_q), 32'h0);
        rst = 1'b0; set_v = 8'h01;
        tick();
        chk("post_rst_q",    32'(b0.q),    32'h01);
        chk("post_rst_rise", 32'(b0.rise), 32'h01);
        chk("post_rst_cnt",  b0.set_cnt,   32'h1);
        set_v = 8'h00;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
